rv32i_regfile_bypass: RTL

RV32I integer register file. It is the responder side of the writeback and operand-read interface: the writeback stage drives wb_enable, wb_reg and wb_data, and the decode stage drives rs1_reg and rs2_reg. Both operand reads are registered, with one-cycle latency and write-first bypass. x0 is hardwired to zero, and a registered debug port supports board-level readback.

---
 rtl/rv32i_regfile_bypass.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/rv32i_regfile_bypass.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_regfile_bypass
// Description : RV32I integer register file with registered operand reads,
//               write-first bypass, x0 hardwired to zero, a registered debug
//               read port, a saturating writeback-event counter and a sticky
//               flag that records attempted writes to x0.
//
// Ports:
//   clk            system clock, all state updates on posedge
//   reset          synchronous active-high reset
//   wb_enable      writeback strobe
//   wb_reg         writeback destination index (5 bits)
//   wb_data        writeback data (XLEN bits)
//   rs1_reg        source-1 read index
//   rs2_reg        source-2 read index
//   rs1_data       registered source-1 value (one-cycle latency)
//   rs2_data       registered source-2 value (one-cycle latency)
//   dbg_reg        debug read index
//   dbg_data       registered debug read value (same rules as rs1/rs2)
//   wb_count       saturating count of effective writes
//   wb_x0_attempt  sticky flag, set when a write to x0 is requested
//
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_regfile_bypass #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,   // must stay 32: register indices are 5 bits wide
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_enable,
    input  logic [4:0]       wb_reg,
    input  logic [XLEN-1:0]  wb_data,
    input  logic [4:0]       rs1_reg,
    input  logic [4:0]       rs2_reg,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    input  logic [4:0]       dbg_reg,
    output logic [XLEN-1:0]  dbg_data,
    output logic [CNT_W-1:0] wb_count,
    output logic             wb_x0_attempt
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    // ------------------------------------------------------------------------
    // Write qualification
    // ------------------------------------------------------------------------
    logic w_wr_effective;   // real architectural write (not to x0)
    logic w_wr_x0;          // write requested to x0, suppressed

    assign w_wr_effective = wb_enable && (wb_reg != 5'd0);
    assign w_wr_x0        = wb_enable && (wb_reg == 5'd0);

    // ------------------------------------------------------------------------
    // Storage: x1..x31 as individual flops. w_file presents a full 32-entry
    // view with entry 0 tied to zero so the read mux needs no range guard.
    // ------------------------------------------------------------------------
    logic [XLEN-1:0] r_regs [1:NREGS-1];
    logic [XLEN-1:0] w_file [NREGS];

    assign w_file[0] = '0;

    generate
        for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_regs[gi] <= '0;
                end else if (w_wr_effective && (wb_reg == 5'(gi))) begin
                    r_regs[gi] <= wb_data;
                end
            end

            assign w_file[gi] = r_regs[gi];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Read-value selection. A write landing on the same edge as the read is
    // forwarded so the consumer sees the new value (write-first). Index 0
    // always reads as zero, even when a write to x0 is requested, because the
    // effective-write qualifier already excludes x0.
    // ------------------------------------------------------------------------
    logic [XLEN-1:0] w_rs1_next;
    logic [XLEN-1:0] w_rs2_next;
    logic [XLEN-1:0] w_dbg_next;

    always_comb begin
        w_rs1_next = w_file[rs1_reg];
        if (w_wr_effective && (wb_reg == rs1_reg)) begin
            w_rs1_next = wb_data;
        end
    end

    always_comb begin
        w_rs2_next = w_file[rs2_reg];
        if (w_wr_effective && (wb_reg == rs2_reg)) begin
            w_rs2_next = wb_data;
        end
    end

    always_comb begin
        w_dbg_next = w_file[dbg_reg];
        if (w_wr_effective && (wb_reg == dbg_reg)) begin
            w_dbg_next = wb_data;
        end
    end

    // ------------------------------------------------------------------------
    // Registered read outputs
    // ------------------------------------------------------------------------
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_dbg_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_dbg_data <= '0;
        end else begin
            r_rs1_data <= w_rs1_next;
            r_rs2_data <= w_rs2_next;
            r_dbg_data <= w_dbg_next;
        end
    end

    // ------------------------------------------------------------------------
    // Writeback-event counter (saturating) and sticky x0-write flag
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] r_wb_count;
    logic             r_wb_x0_attempt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_count      <= '0;
            r_wb_x0_attempt <= 1'b0;
        end else begin
            if (w_wr_effective && (r_wb_count != c_cnt_max)) begin
                r_wb_count <= r_wb_count + CNT_W'(1);
            end
            if (w_wr_x0) begin
                r_wb_x0_attempt <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------------
    assign rs1_data      = r_rs1_data;
    assign rs2_data      = r_rs2_data;
    assign dbg_data      = r_dbg_data;
    assign wb_count      = r_wb_count;
    assign wb_x0_attempt = r_wb_x0_attempt;

endmodule
`default_nettype wire
